sfq_xor_n: RTL and testbench

- Synchronous behavioural model of a generalised clocked RSFQ XOR cell with N_IN pulse inputs, plus OR and AND readout modes.
- Data inputs are single-cycle pulses. A readout strobe reads the internal state and clears it, then emits a result pulse after a configurable delay line.
- Instantiated by cell-level testbenches and VCD timing-assertion flows as the next-generation multi-input replacement for the 2-input clocked XOR.

---
 rtl/sfq_xor_n.sv | 128 ++++++++++++
 tb/tb_sfq_xor_n.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sfq_xor_n.sv
// sfq_xor_n: synchronous behavioural model of a generalised clocked RSFQ XOR
// cell with N_IN pulse inputs and OR / AND readout modes.
//
// Parameters:
//   N_IN  number of pulse inputs (2..16)
//   MODE  readout function: 0 = XOR-annihilate, 1 = OR, 2 = AND
//   LAT   readout-to-output delay in clk cycles (1..8)
//
// Ports:
//   clk         system clock, all state updates on the rising edge
//   rst         synchronous active-high reset
//   din         data pulses, bit i high for one cycle = one pulse on input i
//   rd          readout strobe; samples and clears the internal state
//   out         result pulse, one cycle wide, LAT cycles after rd
//   out_idx     held input index accompanying out (MODE 0 only, else 0)
//   busy        high while a result of 1 is in flight in the delay line
//   collisions  saturating count of annihilation cycles (MODE 0), present
//               only when SFQ_XOR_N_COLLISION_CNT_EN is defined
module sfq_xor_n #(
  parameter int N_IN = 2,
  parameter int MODE = 0,
  parameter int LAT  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_IN-1:0]          din,
  input  logic                     rd,
  output logic                     out,
  output logic [$clog2(N_IN)-1:0]  out_idx,
  output logic                     busy
`ifdef SFQ_XOR_N_COLLISION_CNT_EN
  ,
  output logic [15:0]              collisions
`endif
);

  localparam int IW = $clog2(N_IN);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_HOLD  = 1'b1;

  logic [0:0]        state, state_nx;
  logic [IW-1:0]     hidx, hidx_nx;
  logic [N_IN-1:0]   mask, mask_nx;
  logic [N_IN-1:0]   held_oh;
  logic [N_IN-1:0]   s_eff;
  logic              s_any, s_multi;
  logic [IW-1:0]     s_idx;
  logic              result;
  logic [IW-1:0]     res_idx;
  logic              enter;
  logic [IW-1:0]     enter_idx;

  // Delay line kept as packed vectors so a shift is a truncated concatenation,
  // which stays well-formed for LAT=1.
  logic [LAT-1:0]    vld;
  logic [LAT*IW-1:0] sr_idx;

  always_comb begin
    held_oh = '0;
    if (state == ST_HOLD) held_oh[hidx] = 1'b1;

    // A readout clears the state on this edge, so din lands on an empty cell.
    s_eff = rd ? din : (din | held_oh);

    s_any   = 1'b0;
    s_multi = 1'b0;
    s_idx   = '0;
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (s_eff[i]) begin
        if (s_any) s_multi = 1'b1;
        s_any = 1'b1;
        s_idx = IW'(i);
      end
    end

    state_nx = ST_EMPTY;
    hidx_nx  = '0;
    if (s_any && !s_multi) begin
      state_nx = ST_HOLD;
      hidx_nx  = s_idx;
    end

    mask_nx = rd ? din : (mask | din);

    case (MODE)
      0:       result = (state == ST_HOLD);
      1:       result = |mask;
      default: result = &mask;
    endcase

    res_idx = ((MODE == 0) && (state == ST_HOLD)) ? hidx : '0;

    enter     = rd & result;
    enter_idx = enter ? res_idx : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_EMPTY;
      hidx   <= '0;
      mask   <= '0;
      vld    <= '0;
      sr_idx <= '0;
    end else begin
      state  <= state_nx;
      hidx   <= hidx_nx;
      mask   <= mask_nx;
      vld    <= LAT'({vld, enter});
      sr_idx <= (LAT*IW)'({sr_idx, enter_idx});
    end
  end

  assign out     = vld[LAT-1];
  assign out_idx = sr_idx[LAT*IW-1 -: IW];
  assign busy    = |vld;

`ifdef SFQ_XOR_N_COLLISION_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      collisions <= '0;
    end else if ((MODE == 0) && s_multi && (collisions != 16'hFFFF)) begin
      collisions <= collisions + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sfq_xor_n.sv
// tb_sfq_xor_n: directed self-checking bench for sfq_xor_n. Five instances
// cover the parameter sets: a (N2,M0,L1), b (N4,M0,L3), c (N3,M2,L1),
// d (N3,M1,L2), e (N4,M0,L4). Inputs change 1 time unit after a rising edge
// and outputs are sampled at that same point.
module tb_sfq_xor_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [1:0] din_a; logic rd_a; logic out_a; logic [0:0] idx_a; logic busy_a;
  logic [3:0] din_b; logic rd_b; logic out_b; logic [1:0] idx_b; logic busy_b;
  logic [2:0] din_c; logic rd_c; logic out_c; logic [1:0] idx_c; logic busy_c;
  logic [2:0] din_d; logic rd_d; logic out_d; logic [1:0] idx_d; logic busy_d;
  logic [3:0] din_e; logic rd_e; logic out_e; logic [1:0] idx_e; logic busy_e;
`ifdef SFQ_XOR_N_COLLISION_CNT_EN
  logic [15:0] col_a, col_b, col_c, col_d, col_e;
`endif

  int checks = 0;
  int failures = 0;

  sfq_xor_n #(.N_IN(2), .MODE(0), .LAT(1)) u_a (
    .clk(clk), .rst(rst), .din(din_a), .rd(rd_a), .out(out_a), .out_idx(idx_a), .busy(busy_a)
`ifdef SFQ_XOR_N_COLLISION_CNT_EN
    , .collisions(col_a)
`endif
  );
  sfq_xor_n #(.N_IN(4), .MODE(0), .LAT(3)) u_b (
    .clk(clk), .rst(rst), .din(din_b), .rd(rd_b), .out(out_b), .out_idx(idx_b), .busy(busy_b)
`ifdef SFQ_XOR_N_COLLISION_CNT_EN
    , .collisions(col_b)
`endif
  );
  sfq_xor_n #(.N_IN(3), .MODE(2), .LAT(1)) u_c (
    .clk(clk), .rst(rst), .din(din_c), .rd(rd_c), .out(out_c), .out_idx(idx_c), .busy(busy_c)
`ifdef SFQ_XOR_N_COLLISION_CNT_EN
    , .collisions(col_c)
`endif
  );
  sfq_xor_n #(.N_IN(3), .MODE(1), .LAT(2)) u_d (
    .clk(clk), .rst(rst), .din(din_d), .rd(rd_d), .out(out_d), .out_idx(idx_d), .busy(busy_d)
`ifdef SFQ_XOR_N_COLLISION_CNT_EN
    , .collisions(col_d)
`endif
  );
  sfq_xor_n #(.N_IN(4), .MODE(0), .LAT(4)) u_e (
    .clk(clk), .rst(rst), .din(din_e), .rd(rd_e), .out(out_e), .out_idx(idx_e), .busy(busy_e)
`ifdef SFQ_XOR_N_COLLISION_CNT_EN
    , .collisions(col_e)
`endif
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    din_a = '1; din_b = '1; din_c = '1; din_d = '1; din_e = '1;
    rd_a = 1'b1; rd_b = 1'b1; rd_c = 1'b1; rd_d = 1'b1; rd_e = 1'b1;
    cyc(); cyc();
    checks++; if (out_a !== 1'b0 || busy_a !== 1'b0 || idx_a !== 1'b0) begin failures++; $display("FAIL reset_a got=%0b%0b%0b exp=000", out_a, busy_a, idx_a); end
    checks++; if (out_b !== 1'b0 || busy_b !== 1'b0 || idx_b !== 2'd0) begin failures++; $display("FAIL reset_b got=%0b%0b%0h exp=000", out_b, busy_b, idx_b); end
    checks++; if (out_c !== 1'b0 || busy_c !== 1'b0) begin failures++; $display("FAIL reset_c got=%0b%0b exp=00", out_c, busy_c); end
    checks++; if (out_e !== 1'b0 || busy_e !== 1'b0 || idx_e !== 2'd0) begin failures++; $display("FAIL reset_e got=%0b%0b%0h exp=000", out_e, busy_e, idx_e); end
`ifdef SFQ_XOR_N_COLLISION_CNT_EN
    checks++; if (col_a !== 16'd0 || col_b !== 16'd0 || col_e !== 16'd0) begin failures++; $display("FAIL reset_col got=%0h/%0h/%0h exp=0", col_a, col_b, col_e); end
`endif
    // Readout straight after reset must see an empty cell despite din='1 during rst.
    rst = 1'b0;
    din_a = '0; din_b = '0; din_c = '0; din_d = '0; din_e = '0;
    cyc();
    checks++; if (out_a !== 1'b0 || busy_a !== 1'b0) begin failures++; $display("FAIL reset_rd_a got=%0b%0b exp=00", out_a, busy_a); end
    checks++; if (out_c !== 1'b0) begin failures++; $display("FAIL reset_rd_c got=%0b exp=0", out_c); end
    rd_a = 1'b0; rd_b = 1'b0; rd_c = 1'b0; rd_d = 1'b0; rd_e = 1'b0;
    repeat (4) cyc();
    checks++; if (busy_b !== 1'b0 || busy_d !== 1'b0 || busy_e !== 1'b0) begin failures++; $display("FAIL reset_flush got=%0b%0b%0b exp=000", busy_b, busy_d, busy_e); end
  endtask

  task automatic test_xor_trace();
    din_a = 2'b01; cyc();   // HOLD0
    din_a = 2'b01; cyc();   // HOLD0
    din_a = 2'b10; cyc();   // EMPTY
    din_a = 2'b10; cyc();   // HOLD1
    din_a = 2'b01; cyc();   // EMPTY
    din_a = 2'b00; rd_a = 1'b1; cyc();
    rd_a = 1'b0;
    checks++; if (out_a !== 1'b0 || busy_a !== 1'b0) begin failures++; $display("FAIL trace_out got=%0b%0b exp=00", out_a, busy_a); end
`ifdef SFQ_XOR_N_COLLISION_CNT_EN
    checks++; if (col_a !== 16'd2) begin failures++; $display("FAIL trace_col got=%0d exp=2", col_a); end
`endif
    cyc();
    // Repeated pulses on the same input stay held.
    din_a = 2'b01; cyc();
    din_a = 2'b01; cyc();
    din_a = 2'b00; rd_a = 1'b1; cyc();
    rd_a = 1'b0;
    checks++; if (out_a !== 1'b1 || idx_a !== 1'b0) begin failures++; $display("FAIL repeat_out got=%0b idx=%0d exp=1 idx=0", out_a, idx_a); end
    cyc();
    checks++; if (out_a !== 1'b0 || busy_a !== 1'b0) begin failures++; $display("FAIL repeat_clear got=%0b%0b exp=00", out_a, busy_a); end
  endtask

  task automatic test_delay();
    din_b = 4'b0100; cyc();
    din_b = 4'b0000; repeat (4) cyc();
    rd_b = 1'b1; cyc();     // E
    checks++; if (out_b !== 1'b0 || busy_b !== 1'b1) begin failures++; $display("FAIL delay_e0 got=%0b%0b exp=01", out_b, busy_b); end
    cyc();                  // E+1, second rd reads an empty cell
    rd_b = 1'b0;
    checks++; if (out_b !== 1'b0 || busy_b !== 1'b1) begin failures++; $display("FAIL delay_e1 got=%0b%0b exp=01", out_b, busy_b); end
    cyc();                  // E+2
    checks++; if (out_b !== 1'b1 || idx_b !== 2'd2 || busy_b !== 1'b1) begin failures++; $display("FAIL delay_e2 got=%0b idx=%0d busy=%0b exp=1 idx=2 busy=1", out_b, idx_b, busy_b); end
    cyc();                  // E+3
    checks++; if (out_b !== 1'b0 || idx_b !== 2'd0 || busy_b !== 1'b0) begin failures++; $display("FAIL delay_e3 got=%0b idx=%0d busy=%0b exp=0 idx=0 busy=0", out_b, idx_b, busy_b); end
  endtask

  task automatic test_annihilate();
    din_b = 4'b0101; cyc();
    din_b = 4'b0000; rd_b = 1'b1; cyc();
    rd_b = 1'b0; cyc(); cyc();
    checks++; if (out_b !== 1'b0 || busy_b !== 1'b0) begin failures++; $display("FAIL annih_out got=%0b%0b exp=00", out_b, busy_b); end
`ifdef SFQ_XOR_N_COLLISION_CNT_EN
    checks++; if (col_b !== 16'd1) begin failures++; $display("FAIL annih_col got=%0d exp=1", col_b); end
`endif
    cyc();
    din_b = 4'b1000; cyc();
    din_b = 4'b0000; rd_b = 1'b1; cyc();
    rd_b = 1'b0; cyc(); cyc();
    checks++; if (out_b !== 1'b1 || idx_b !== 2'd3) begin failures++; $display("FAIL rearm_out got=%0b idx=%0d exp=1 idx=3", out_b, idx_b); end
    cyc();
  endtask

  task automatic test_and();
    din_c = 3'b001; cyc();
    din_c = 3'b100; cyc();
    din_c = 3'b000; rd_c = 1'b1; cyc();
    rd_c = 1'b0;
    checks++; if (out_c !== 1'b0) begin failures++; $display("FAIL and_partial got=%0b exp=0", out_c); end
    din_c = 3'b001; cyc();
    din_c = 3'b010; cyc();
    din_c = 3'b100; cyc();
    din_c = 3'b000; rd_c = 1'b1; cyc();
    rd_c = 1'b0;
    checks++; if (out_c !== 1'b1 || idx_c !== 2'd0) begin failures++; $display("FAIL and_full got=%0b idx=%0d exp=1 idx=0", out_c, idx_c); end
    cyc();
    checks++; if (out_c !== 1'b0 || busy_c !== 1'b0) begin failures++; $display("FAIL and_clear got=%0b%0b exp=00", out_c, busy_c); end
`ifdef SFQ_XOR_N_COLLISION_CNT_EN
    checks++; if (col_c !== 16'd0) begin failures++; $display("FAIL and_col got=%0d exp=0", col_c); end
`endif
  endtask

  task automatic test_or();
    rd_d = 1'b1; cyc();                      // empty mask
    rd_d = 1'b0; din_d = 3'b011; cyc();
    checks++; if (out_d !== 1'b0) begin failures++; $display("FAIL or_empty got=%0b exp=0", out_d); end
    din_d = 3'b000; rd_d = 1'b1; cyc();      // E2
    rd_d = 1'b0; cyc();                      // E3
    checks++; if (out_d !== 1'b1 || idx_d !== 2'd0) begin failures++; $display("FAIL or_set got=%0b idx=%0d exp=1 idx=0", out_d, idx_d); end
    cyc();
    checks++; if (out_d !== 1'b0 || busy_d !== 1'b0) begin failures++; $display("FAIL or_clear got=%0b%0b exp=00", out_d, busy_d); end
`ifdef SFQ_XOR_N_COLLISION_CNT_EN
    checks++; if (col_d !== 16'd0) begin failures++; $display("FAIL or_col got=%0d exp=0", col_d); end
`endif
  endtask

  task automatic test_simultaneous();
    din_a = 2'b10; cyc();
    din_a = 2'b01; rd_a = 1'b1; cyc();
    checks++; if (out_a !== 1'b1 || idx_a !== 1'b1) begin failures++; $display("FAIL simul_first got=%0b idx=%0d exp=1 idx=1", out_a, idx_a); end
    din_a = 2'b00; cyc();
    checks++; if (out_a !== 1'b1 || idx_a !== 1'b0) begin failures++; $display("FAIL simul_second got=%0b idx=%0d exp=1 idx=0", out_a, idx_a); end
    rd_a = 1'b0; cyc();
    checks++; if (out_a !== 1'b0 || busy_a !== 1'b0 || idx_a !== 1'b0) begin failures++; $display("FAIL simul_clear got=%0b%0b%0b exp=000", out_a, busy_a, idx_a); end
  endtask

  task automatic test_back_to_back();
    din_b = 4'b0010; cyc();
    din_b = 4'b1000; rd_b = 1'b1; cyc();     // E0: result 1 idx 1
    din_b = 4'b0000; cyc();                  // E1: result 1 idx 3
    cyc();                                   // E2: result 0
    checks++; if (out_b !== 1'b1 || idx_b !== 2'd1) begin failures++; $display("FAIL b2b_0 got=%0b idx=%0d exp=1 idx=1", out_b, idx_b); end
    rd_b = 1'b0; cyc();
    checks++; if (out_b !== 1'b1 || idx_b !== 2'd3) begin failures++; $display("FAIL b2b_1 got=%0b idx=%0d exp=1 idx=3", out_b, idx_b); end
    cyc();
    checks++; if (out_b !== 1'b0 || idx_b !== 2'd0) begin failures++; $display("FAIL b2b_2 got=%0b idx=%0d exp=0 idx=0", out_b, idx_b); end
    cyc();
    checks++; if (busy_b !== 1'b0) begin failures++; $display("FAIL b2b_busy got=%0b exp=0", busy_b); end
  endtask

  task automatic test_reset_midflight();
    din_e = 4'b0011; cyc();                  // collision
    din_e = 4'b0010; cyc();                  // HOLD1
    din_e = 4'b0000; rd_e = 1'b1; cyc();     // E
    rd_e = 1'b0;
    checks++; if (busy_e !== 1'b1 || out_e !== 1'b0) begin failures++; $display("FAIL mid_busy got=%0b%0b exp=10", busy_e, out_e); end
`ifdef SFQ_XOR_N_COLLISION_CNT_EN
    checks++; if (col_e !== 16'd1) begin failures++; $display("FAIL mid_col_pre got=%0d exp=1", col_e); end
`endif
    cyc();                                   // E+1
    rst = 1'b1; cyc();                       // E+2
    rst = 1'b0;
    checks++; if (busy_e !== 1'b0 || out_e !== 1'b0 || idx_e !== 2'd0) begin failures++; $display("FAIL mid_rst got=%0b%0b%0d exp=000", busy_e, out_e, idx_e); end
`ifdef SFQ_XOR_N_COLLISION_CNT_EN
    checks++; if (col_e !== 16'd0) begin failures++; $display("FAIL mid_col_post got=%0d exp=0", col_e); end
`endif
    for (int k = 0; k < 4; k++) begin
      cyc();
      checks++; if (out_e !== 1'b0 || busy_e !== 1'b0) begin failures++; $display("FAIL mid_quiet%0d got=%0b%0b exp=00", k, out_e, busy_e); end
    end
    // State must be EMPTY after reset: a fresh readout yields nothing.
    rd_e = 1'b1; cyc();
    rd_e = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++; if (out_e !== 1'b0 || busy_e !== 1'b0) begin failures++; $display("FAIL mid_empty%0d got=%0b%0b exp=00", k, out_e, busy_e); end
      cyc();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_xor_trace();
    test_delay();
    test_annihilate();
    test_and();
    test_or();
    test_simultaneous();
    test_back_to_back();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
